// File: rtl/bpu_update_sched.sv
// bpu_update_sched: buffers branch correction records from the EXE-stage
// resolver in a small FIFO and drains them into the single-ported BTB/PHT
// write port whenever the IF-stage lookup leaves the port idle. A record
// that has been blocked for too long forces a write and stalls IF lookup.
// Optional build macro BPU_UPD_COALESCE_EN: a new record with the same PC as
// the tail entry overwrites that entry in place instead of taking a new slot.
module bpu_update_sched #(
  parameter int DEPTH      = 4,
  parameter int INDEX_W    = 9,
  parameter int TAG_W      = 8,
  parameter int STARVE_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               upd_valid,
  input  logic [31:0]        upd_pc,
  input  logic [1:0]         upd_type,
  input  logic               upd_taken,
  input  logic [31:0]        upd_target,
  input  logic [1:0]         upd_count,
  input  logic               upd_hit,
  output logic               upd_ready,
  input  logic               lookup_req,
  output logic               lookup_stall,
  output logic               wr_en,
  output logic [INDEX_W-1:0] wr_index,
  output logic [TAG_W-1:0]   wr_tag,
  output logic [31:0]        wr_target,
  output logic [1:0]         wr_type,
  output logic [1:0]         wr_count,
  output logic [15:0]        drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [7:0] STARVE_LIMIT = 8'(STARVE_MAX - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_FORCE = 2'd2;

  localparam logic [1:0] TYPE_IMME = 2'b01;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  btype;
    logic        taken;
    logic [31:0] target;
    logic [1:0]  count;
    logic        hit;
  } entry_t;

  entry_t         mem [DEPTH];
  entry_t         head;
  entry_t         in_rec;
  logic [PTR_W:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [1:0]     state, state_nxt;
  logic [7:0]     starve_cnt, starve_nxt;
  logic           empty, full, empty_nxt;
  logic           skip, grant, pop, wr_fire;
  logic           enq, drop, coalesce, blocked, force_go;

  assign in_rec = {upd_pc, upd_type, upd_taken, upd_target, upd_count, upd_hit};
  assign head   = mem[rd_ptr[PTR_W-1:0]];

  // The extra wrap bit distinguishes a full FIFO from an empty one.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  // A missed, not-taken conditional branch needs no BTB allocation.
  assign skip = !head.hit && !head.taken && (head.btype == TYPE_IMME) &&
                (head.target == (head.pc + 32'd8));

  // FORCE owns the port outright; DRAIN only takes it when IF leaves it free.
  always_comb begin
    grant = 1'b0;
    case (state)
      ST_DRAIN: grant = !lookup_req;
      ST_FORCE: grant = 1'b1;
      default:  grant = 1'b0;
    endcase
  end

  assign pop     = grant && !empty;
  assign wr_fire = pop && !skip;
  assign blocked = (state == ST_DRAIN) && lookup_req && !empty;

`ifdef BPU_UPD_COALESCE_EN
  localparam logic [PTR_W-1:0] IDX_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
  logic [PTR_W-1:0] tail_idx;
  logic [PTR_W:0]   occupancy;

  assign tail_idx  = wr_ptr[PTR_W-1:0] - IDX_ONE;
  assign occupancy = wr_ptr - rd_ptr;
  // Merge only when the tail survives this cycle, i.e. it is not the entry being popped.
  assign coalesce  = upd_valid && !empty && (mem[tail_idx].pc == upd_pc) &&
                     !(pop && (occupancy == PTR_ONE));
`else
  assign coalesce  = 1'b0;
`endif

  assign upd_ready = !full || wr_fire || coalesce;
  assign enq       = upd_valid && upd_ready && !coalesce;
  assign drop      = upd_valid && !upd_ready;

  assign wr_ptr_nxt = enq ? (wr_ptr + PTR_ONE) : wr_ptr;
  assign rd_ptr_nxt = pop ? (rd_ptr + PTR_ONE) : rd_ptr;
  assign empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
  assign force_go   = blocked && ((starve_cnt + 8'd1) >= STARVE_LIMIT);

  // Next-state and starvation counter: any grant resets the wait, blocked cycles accumulate it.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    case (state)
      ST_IDLE: begin
        starve_nxt = 8'd0;
        state_nxt  = empty_nxt ? ST_IDLE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop) begin
          starve_nxt = 8'd0;
        end else if (blocked) begin
          starve_nxt = starve_cnt + 8'd1;
        end
        if (empty_nxt) begin
          state_nxt = ST_IDLE;
        end else if (force_go) begin
          state_nxt = ST_FORCE;
        end else begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_FORCE: begin
        starve_nxt = 8'd0;
        state_nxt  = empty_nxt ? ST_IDLE : ST_DRAIN;
      end
      default: begin
        starve_nxt = 8'd0;
        state_nxt  = ST_IDLE;
      end
    endcase
  end

  // Control state; reset discards every queued record.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      state      <= ST_IDLE;
      starve_cnt <= 8'd0;
      drop_cnt   <= 16'd0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      if (drop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // Record storage; contents beyond the pointers are never observed, so no reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr[PTR_W-1:0]] <= in_rec;
    end
`ifdef BPU_UPD_COALESCE_EN
    else if (coalesce) begin
      mem[tail_idx] <= in_rec;
    end
`endif
  end

  assign lookup_stall = (state == ST_FORCE);
  assign wr_en        = wr_fire;
  assign wr_index     = wr_fire ? head.pc[INDEX_W+1:2] : '0;
  assign wr_tag       = wr_fire ? head.pc[INDEX_W+2 +: TAG_W] : '0;
  assign wr_target    = wr_fire ? head.target : 32'd0;
  assign wr_type      = wr_fire ? head.btype : 2'b00;

  // New 2-bit counter: hits move saturating toward the outcome, misses start weak.
  always_comb begin
    wr_count = 2'b00;
    if (wr_fire) begin
      if (head.hit) begin
        if (head.taken) begin
          wr_count = (head.count == 2'b11) ? 2'b11 : (head.count + 2'b01);
        end else begin
          wr_count = (head.count == 2'b00) ? 2'b00 : (head.count - 2'b01);
        end
      end else begin
        wr_count = head.taken ? 2'b10 : 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_bpu_update_sched.sv
// tb_bpu_update_sched: directed bench for bpu_update_sched. Accepted records
// are turned into expected writes and queued; every observed write pops and
// compares the oldest expectation.
module tb_bpu_update_sched;

  localparam int DEPTH      = 4;
  localparam int INDEX_W    = 9;
  localparam int TAG_W      = 8;
  localparam int STARVE_MAX = 8;

  logic               clk;
  logic               rst;
  logic               upd_valid;
  logic [31:0]        upd_pc;
  logic [1:0]         upd_type;
  logic               upd_taken;
  logic [31:0]        upd_target;
  logic [1:0]         upd_count;
  logic               upd_hit;
  logic               upd_ready;
  logic               lookup_req;
  logic               lookup_stall;
  logic               wr_en;
  logic [INDEX_W-1:0] wr_index;
  logic [TAG_W-1:0]   wr_tag;
  logic [31:0]        wr_target;
  logic [1:0]         wr_type;
  logic [1:0]         wr_count;
  logic [15:0]        drop_cnt;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  btype;
    logic        taken;
    logic [31:0] target;
    logic [1:0]  count;
    logic        hit;
  } rec_t;

  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic [31:0]        target;
    logic [1:0]         btype;
    logic [1:0]         count;
  } wr_exp_t;

  wr_exp_t sb[$];
  int      n_asserts;
  int      n_fails;
  int      exp_drop;

  bpu_update_sched #(
    .DEPTH(DEPTH), .INDEX_W(INDEX_W), .TAG_W(TAG_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_type(upd_type),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_count(upd_count),
    .upd_hit(upd_hit), .upd_ready(upd_ready),
    .lookup_req(lookup_req), .lookup_stall(lookup_stall),
    .wr_en(wr_en), .wr_index(wr_index), .wr_tag(wr_tag),
    .wr_target(wr_target), .wr_type(wr_type), .wr_count(wr_count),
    .drop_cnt(drop_cnt)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic rec_t mk_rec(input logic [31:0] pc, input logic [1:0] t, input logic tk,
                                  input logic [31:0] tgt, input logic [1:0] cnt, input logic h);
    return {pc, t, tk, tgt, cnt, h};
  endfunction

  function automatic logic is_skip(input rec_t r);
    return !r.hit && !r.taken && (r.btype == 2'b01) && (r.target == r.pc + 32'd8);
  endfunction

  // Reference write produced by a record.
  function automatic wr_exp_t model(input rec_t r);
    wr_exp_t m;
    m.index  = r.pc[INDEX_W+1:2];
    m.tag    = r.pc[INDEX_W+2 +: TAG_W];
    m.target = r.target;
    m.btype  = r.btype;
    if (!r.hit)       m.count = r.taken ? 2'd2 : 2'd1;
    else if (r.taken) m.count = (r.count == 2'd3) ? 2'd3 : r.count + 2'd1;
    else              m.count = (r.count == 2'd0) ? 2'd0 : r.count - 2'd1;
    return m;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One cycle: drive at negedge, sample 1 ns later, score any write, then queue the new expectation.
  task automatic applyStimulus(input logic v, input rec_t r, input logic lreq,
                               input logic exp_acc, input logic merge);
    wr_exp_t e;
    @(negedge clk);
    upd_valid  = v;
    upd_pc     = r.pc;
    upd_type   = r.btype;
    upd_taken  = r.taken;
    upd_target = r.target;
    upd_count  = r.count;
    upd_hit    = r.hit;
    lookup_req = lreq;
    #1;
    if (wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_wr", 32'(wr_en), 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("wr_index",  32'(wr_index), 32'(e.index));
        checkOutput("wr_tag",    32'(wr_tag),   32'(e.tag));
        checkOutput("wr_target", wr_target,     e.target);
        checkOutput("wr_type",   32'(wr_type),  32'(e.btype));
        checkOutput("wr_count",  32'(wr_count), 32'(e.count));
      end
    end
    if (v) begin
      checkOutput("upd_ready", 32'(upd_ready), 32'(exp_acc));
      if (!exp_acc)                       exp_drop++;
      else if (merge && sb.size() > 0)    sb[$] = model(r);
      else if (!is_skip(r))               sb.push_back(model(r));
    end
  endtask

  task automatic idle_cycles(input logic lreq, input int n);
    rec_t z;
    z = '0;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, z, lreq, 1'b0, 1'b0);
  endtask

  initial begin
    rec_t r;
    rec_t burst [7];
    rec_t a;
    rec_t b;
    n_asserts  = 0;
    n_fails    = 0;
    exp_drop   = 0;
    rst        = 1'b1;
    upd_valid  = 1'b0;
    upd_pc     = 32'd0;
    upd_type   = 2'd0;
    upd_taken  = 1'b0;
    upd_target = 32'd0;
    upd_count  = 2'd0;
    upd_hit    = 1'b0;
    lookup_req = 1'b0;

    // Reset values.
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_upd_ready", 32'(upd_ready), 32'd1);
    checkOutput("rst_wr_en",     32'(wr_en), 32'd0);
    checkOutput("rst_stall",     32'(lookup_stall), 32'd0);
    checkOutput("rst_drop_cnt",  32'(drop_cnt), 32'd0);
    checkOutput("rst_wr_index",  32'(wr_index), 32'd0);
    checkOutput("rst_wr_target", wr_target, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single hit/taken record written the following cycle.
    $display("[TB] single record");
    r = mk_rec(32'h8000_0010, 2'b01, 1'b1, 32'h8000_0400, 2'd2, 1'b1);
    applyStimulus(1'b1, r, 1'b0, 1'b1, 1'b0);
    idle_cycles(1'b0, 1);
    checkOutput("t1_wr_en",  32'(wr_en), 32'd1);
    checkOutput("t1_index",  32'(wr_index), 32'h004);
    checkOutput("t1_count",  32'(wr_count), 32'd3);
    checkOutput("t1_target", wr_target, 32'h8000_0400);
    idle_cycles(1'b0, 1);
    checkOutput("t1_empty_after", 32'(wr_en), 32'd0);

    // Skipped conditional miss pops silently.
    $display("[TB] skip record");
    r = mk_rec(32'h0000_1230, 2'b01, 1'b0, 32'h0000_1238, 2'd1, 1'b0);
    applyStimulus(1'b1, r, 1'b0, 1'b1, 1'b0);
    idle_cycles(1'b0, 1);
    checkOutput("t2_skip_no_wr", 32'(wr_en), 32'd0);
    checkOutput("t2_drop_cnt",   32'(drop_cnt), 32'd0);

    // Back-to-back records covering every counter rule and the skip/no-skip boundary.
    $display("[TB] counter burst");
    burst[0] = mk_rec(32'h0004_5A3C, 2'b01, 1'b0, 32'h0004_6000, 2'd0, 1'b1);
    burst[1] = mk_rec(32'h1234_5678, 2'b10, 1'b1, 32'h0000_2000, 2'd3, 1'b1);
    burst[2] = mk_rec(32'h0000_0FFC, 2'b11, 1'b1, 32'h4000_0000, 2'd0, 1'b0);
    burst[3] = mk_rec(32'h0ABC_0100, 2'b01, 1'b0, 32'h0ABC_0200, 2'd2, 1'b0);
    burst[4] = mk_rec(32'h0ABC_0200, 2'b01, 1'b0, 32'h0ABC_0208, 2'd2, 1'b0);
    burst[5] = mk_rec(32'h0ABC_0300, 2'b10, 1'b0, 32'h0ABC_0308, 2'd3, 1'b0);
    burst[6] = mk_rec(32'h7FFF_FFF0, 2'b01, 1'b1, 32'h0000_0100, 2'd1, 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, burst[i], 1'b0, 1'b1, 1'b0);
    idle_cycles(1'b0, 2);
    checkOutput("t2_sb_empty", 32'(sb.size()), 32'd0);

    // Starvation: forced write exactly STARVE_MAX cycles after enqueue.
    $display("[TB] starvation");
    r = mk_rec(32'h0000_2000, 2'b10, 1'b1, 32'h0000_3000, 2'd1, 1'b1);
    applyStimulus(1'b1, r, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i < STARVE_MAX; i++) begin
      idle_cycles(1'b1, 1);
      checkOutput("t3_stall_early", 32'(lookup_stall), 32'd0);
      checkOutput("t3_wr_early",    32'(wr_en), 32'd0);
    end
    idle_cycles(1'b1, 1);
    checkOutput("t3_stall_force", 32'(lookup_stall), 32'd1);
    checkOutput("t3_wr_force",    32'(wr_en), 32'd1);
    idle_cycles(1'b1, 1);
    checkOutput("t3_stall_after", 32'(lookup_stall), 32'd0);
    checkOutput("t3_wr_after",    32'(wr_en), 32'd0);

    // Overflow: fifth record while blocked is dropped.
    $display("[TB] overflow");
    for (int i = 0; i < 5; i++) begin
      r = mk_rec(32'h0000_0100 * (i + 1), 2'b01, i[0], 32'h0001_0000 + 32'(i), 2'(i), 1'b1);
      applyStimulus(1'b1, r, 1'b1, (i < 4), 1'b0);
    end
    idle_cycles(1'b0, 5);
    checkOutput("t4_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    checkOutput("t4_sb_empty", 32'(sb.size()), 32'd0);

    // Full FIFO with a free port: simultaneous pop and push keeps it full.
    $display("[TB] full pass-through");
    for (int i = 0; i < 4; i++) begin
      r = mk_rec(32'h0020_0000 + 32'(i * 4), 2'b11, 1'b1, 32'h0030_0000 + 32'(i), 2'd1, 1'b0);
      applyStimulus(1'b1, r, 1'b1, 1'b1, 1'b0);
    end
    r = mk_rec(32'h0020_0040, 2'b10, 1'b0, 32'h0030_0040, 2'd2, 1'b1);
    applyStimulus(1'b1, r, 1'b0, 1'b1, 1'b0);
    r = mk_rec(32'h0020_0080, 2'b10, 1'b1, 32'h0030_0080, 2'd2, 1'b1);
    applyStimulus(1'b1, r, 1'b1, 1'b0, 1'b0);
    idle_cycles(1'b0, 5);
    checkOutput("t5_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    checkOutput("t5_sb_empty", 32'(sb.size()), 32'd0);

    // Asynchronous reset while draining three records.
    $display("[TB] reset mid-drain");
    for (int i = 0; i < 3; i++) begin
      r = mk_rec(32'h0040_0000 + 32'(i * 16), 2'b01, 1'b1, 32'h0050_0000, 2'd0, 1'b0);
      applyStimulus(1'b1, r, 1'b1, 1'b1, 1'b0);
    end
    idle_cycles(1'b0, 1);
    checkOutput("t6_wr_before", 32'(wr_en), 32'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("t6_wr_async",   32'(wr_en), 32'd0);
    checkOutput("t6_stall",      32'(lookup_stall), 32'd0);
    checkOutput("t6_upd_ready",  32'(upd_ready), 32'd1);
    checkOutput("t6_drop_clear", 32'(drop_cnt), 32'd0);
    sb.delete();
    exp_drop = 0;
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(1'b0, 3);
    r = mk_rec(32'h0000_2400, 2'b10, 1'b0, 32'h0000_3400, 2'd2, 1'b1);
    applyStimulus(1'b1, r, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i < STARVE_MAX; i++) begin
      idle_cycles(1'b1, 1);
      checkOutput("t6_starve_early", 32'(lookup_stall), 32'd0);
    end
    idle_cycles(1'b1, 1);
    checkOutput("t6_starve_force", 32'(lookup_stall), 32'd1);
    idle_cycles(1'b0, 2);

    // Same-PC records back to back while blocked.
    $display("[TB] same-pc records");
    a = mk_rec(32'h0000_5550, 2'b01, 1'b1, 32'h0000_6000, 2'd1, 1'b1);
    b = mk_rec(32'h0000_5550, 2'b10, 1'b0, 32'h0000_7000, 2'd1, 1'b1);
    applyStimulus(1'b1, a, 1'b1, 1'b1, 1'b0);
`ifdef BPU_UPD_COALESCE_EN
    applyStimulus(1'b1, b, 1'b1, 1'b1, 1'b1);
`else
    applyStimulus(1'b1, b, 1'b1, 1'b1, 1'b0);
`endif
    idle_cycles(1'b0, 4);
    checkOutput("t7_sb_empty", 32'(sb.size()), 32'd0);
    checkOutput("t7_drop_cnt", 32'(drop_cnt), 32'(exp_drop));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/bpu_update_sched.md
Name: bpu_update_sched

Overview:
- Sits between the EXE-stage branch resolver and the single-ported BTB/PHT arrays of the branch prediction unit.
- Captures per-branch correction records each cycle and buffers them in a small FIFO.
- Drains the FIFO into the array write port whenever the IF-stage lookup leaves the port free.
- Forces a write, stalling lookup, when an update has waited too long.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
INDEX_W, 9, BTB/PHT index width; index = pc[INDEX_W+1:2]
TAG_W, 8, tag width; tag = pc[INDEX_W+2 +: TAG_W]
STARVE_MAX, 8, blocked-cycle limit before a forced write; range 1..255

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
upd_valid  in  1  correction record valid; resolver already gates it with the pipeline write enable and type != None
upd_pc  in  32  branch PC
upd_type  in  2  None/Imme/Call/Retn encoding, as in the BResult type
upd_taken  in  1  resolved direction
upd_target  in  32  resolved target
upd_count  in  2  predictor 2-bit counter carried from lookup
upd_hit  in  1  lookup hit BTB
upd_ready  out  1  record will be accepted this cycle
lookup_req  in  1  IF stage uses array port this cycle
lookup_stall  out  1  IF must not look up this cycle (forced write)
wr_en  out  1  array write strobe
wr_index  out  INDEX_W  write index
wr_tag  out  TAG_W  write tag
wr_target  out  32  write target
wr_type  out  2  write type
wr_count  out  2  new counter value
drop_cnt  out  16  saturating count of records lost to overflow

Behaviour:
- Reset (async, rst=1): FIFO empty, pointers 0, starve_cnt=0, drop_cnt=0, state=IDLE. All outputs 0 except upd_ready=1.
- FIFO entry contents: pc, type, taken, target, count, hit.
- Enqueue condition: upd_valid && upd_ready. Write happens at the clk edge.
- Acceptance latency: a record accepted at cycle t appears at the head no earlier than t+1.
- upd_ready = !full || wr_fire. This gives simultaneous dequeue+enqueue when full.
- Overflow: upd_valid && !upd_ready drops the record and increments drop_cnt. drop_cnt saturates at 0xFFFF. The resolver is never stalled.
- Skip rule, evaluated on the head entry: if !hit && !taken && type==Imme && head is conditional (target==pc+8), no allocation is made. Such an entry pops without asserting wr_en. It still consumes a grant slot.
- wr_count for hit entries: taken gives saturating increment (3 stays 3); not taken gives saturating decrement (0 stays 0).
- wr_count for miss entries: taken gives 2'b10; not taken gives 2'b01.
- Other write fields: wr_index and wr_tag are sliced from the head pc; wr_target and wr_type are copied from the head entry.
- All wr_* outputs are combinational from the FIFO head and the grant.
- State machine:
  - IDLE: FIFO empty; wr_en=0. Go to DRAIN on enqueue.
  - DRAIN: grant = !lookup_req.
    - With grant: wr_fire, pop, starve_cnt←0.
    - Without grant: starve_cnt++.
    - If starve_cnt reaches STARVE_MAX-1 while blocked, go to FORCE.
    - If FIFO empties after a pop with no enqueue, go to IDLE.
  - FORCE: lookup_stall=1, grant=1 regardless of lookup_req; one pop, starve_cnt←0. Then go to DRAIN if non-empty, else IDLE.
- lookup_stall is asserted only in FORCE. It is registered-state driven, with no combinational path from lookup_req.
- wr_fire = grant && !empty && !skip. Pop = grant && !empty.
- Pointers wrap modulo DEPTH. full/empty use an extra wrap bit.
- Reset mid-operation clears all queued records; no partial write completes.

Optional Feature:
- Macro: BPU_UPD_COALESCE_EN.
- Defined: if upd_valid and the FIFO is non-empty and upd_pc equals the tail entry pc, and the tail is not being popped this cycle:
  - the tail entry is overwritten in place with the new record;
  - no pointer advances;
  - upd_ready=1 even when full.
  Otherwise enqueue as normal.
- Undefined: every record takes its own entry; no PC comparator is built.

Test Plan:
- Reset, then one record (pc=0x8000_0010, taken=1, hit=1, count=2), lookup_req=0 → wr_en=1 the next cycle with index=0x004, count=3, target as given; FIFO empty afterward.
- Miss, not-taken, conditional record (target=pc+8) with lookup_req=0 → entry pops, wr_en stays 0, drop_cnt=0.
- lookup_req held at 1, one queued record, STARVE_MAX=8 → lookup_stall=1 and wr_en=1 in exactly one cycle, 8 cycles after enqueue; lookup_stall=0 afterwards.
- DEPTH=4, lookup_req=1, five valid records on consecutive cycles → fifth is rejected (upd_ready=0) and drop_cnt=1; after releasing lookup_req, four writes occur in FIFO order.
- Full FIFO with lookup_req=0 and upd_valid=1 → upd_ready=1; pop and push occur the same cycle and occupancy stays 4.
- rst pulsed mid-drain with 3 queued records → wr_en=0 immediately (async), FIFO empty, starve_cnt=0.
- With BPU_UPD_COALESCE_EN defined: two back-to-back records with the same pc (taken, then not taken) while blocked → a single write carrying the second record's values.
